// File: rtl/mmio_store_port.sv
// Memory-mapped store port: captures CPU stores to one address into a small
// first-word-fall-through FIFO drained over a valid/ready handshake.
module mmio_store_port #(
   parameter int            N         = 16,
   parameter logic [N-1:0]  PORT_ADDR = 16'h0054,
   parameter int            DEPTH     = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   memwrite,
   input  logic [N-1:0]           dataadr,
   input  logic [N-1:0]           writedata,
   output logic [N-1:0]           out_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   full,
   output logic [$clog2(DEPTH):0] level,
   output logic [7:0]             captured,
   output logic [7:0]             dropped
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [N-1:0]  mem_q [DEPTH];
   logic [AW-1:0] head_q, head_d;
   logic [AW-1:0] tail_q, tail_d;
   logic [LW-1:0] level_q, level_d;
   logic [7:0]    captured_q, captured_d;
   logic [7:0]    dropped_q, dropped_d;

   logic push_req;
   logic pop;
   logic push_acc;
   logic push_drop;
   logic full_w;

   assign full_w    = (level_q == LW'(DEPTH));
   assign push_req  = memwrite && (dataadr == PORT_ADDR);
   assign pop       = (level_q != '0) && out_ready;
   // A full FIFO still accepts a store when a word leaves on the same edge.
   assign push_acc  = push_req && (!full_w || pop);
   assign push_drop = push_req && full_w && !pop;

   always_comb begin
      head_d     = head_q;
      tail_d     = tail_q;
      level_d    = level_q;
      captured_d = captured_q;
      dropped_d  = dropped_q;
      if (pop) begin
         head_d = head_q + AW'(1);
      end
      if (push_acc) begin
         tail_d     = tail_q + AW'(1);
         captured_d = captured_q + 8'd1;
      end
      if (push_acc && !pop) begin
         level_d = level_q + LW'(1);
      end else if (pop && !push_acc) begin
         level_d = level_q - LW'(1);
      end
      if (push_drop && (dropped_q != 8'hFF)) begin
         dropped_d = dropped_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head_q     <= '0;
         tail_q     <= '0;
         level_q    <= '0;
         captured_q <= '0;
         dropped_q  <= '0;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         level_q    <= level_d;
         captured_q <= captured_d;
         dropped_q  <= dropped_d;
      end
   end

   // Storage is not reset; its contents only matter where level marks them live.
   always_ff @(posedge clk) begin
      if (push_acc) begin
         mem_q[tail_q] <= writedata;
      end
   end

   assign out_data  = mem_q[head_q];
   assign out_valid = (level_q != '0);
   assign full      = full_w;
   assign level     = level_q;
   assign captured  = captured_q;
   assign dropped   = dropped_q;

endmodule

// File: tb/tb_mmio_store_port.sv
// Scoreboard bench for mmio_store_port: expected words queued on accepted
// stores and compared as the port pops them.
module tb_mmio_store_port;

   logic        clk;
   logic        reset;
   logic        memwrite;
   logic [15:0] dataadr;
   logic [15:0] writedata;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        full;
   logic [2:0]  level;
   logic [7:0]  captured;
   logic [7:0]  dropped;

   mmio_store_port #(.N(16), .PORT_ADDR(16'h0054), .DEPTH(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .memwrite  (memwrite),
      .dataadr   (dataadr),
      .writedata (writedata),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .full      (full),
      .level     (level),
      .captured  (captured),
      .dropped   (dropped)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [15:0] sb_q[$];
   int          m_cap;
   int          m_drop;
   int          n_cmp;
   int          n_err;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_clear();
      sb_q.delete();
      m_cap  = 0;
      m_drop = 0;
   endtask

   // One clock: drive inputs, compare/update scoreboard at negedge, advance past posedge.
   task automatic step(input logic mw, input logic [15:0] adr, input logic [15:0] wd,
                       input logic rdy);
      logic pop_m;
      logic push_m;
      logic full_m;
      memwrite  = mw;
      dataadr   = adr;
      writedata = wd;
      out_ready = rdy;
      @(negedge clk);
      check("valid", out_valid, (sb_q.size() != 0));
      check("level", level, sb_q.size());
      full_m = (sb_q.size() == 4);
      pop_m  = (sb_q.size() != 0) && rdy;
      push_m = mw && (adr == 16'h0054);
      if (pop_m) check("pop_data", out_data, sb_q.pop_front());
      if (push_m) begin
         if (!full_m || pop_m) begin
            sb_q.push_back(wd);
            m_cap = (m_cap + 1) % 256;
         end else if (m_drop != 255) begin
            m_drop++;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_counters();
      check("captured", captured, m_cap);
      check("dropped", dropped, m_drop);
      check("full", full, (sb_q.size() == 4));
   endtask

   // Asynchronous reset applied and released between clock edges.
   task automatic do_reset();
      memwrite  = 1'b0;
      out_ready = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      model_clear();
      @(negedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 16'h0000, 16'h0000, 1'b1);
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      model_clear();
      reset     = 1'b0;
      memwrite  = 1'b0;
      dataadr   = '0;
      writedata = '0;
      out_ready = 1'b0;
      #3;
      check("rst_valid", out_valid, 1'b0);
      check("rst_full", full, 1'b0);
      check("rst_level", level, 3'd0);
      check("rst_captured", captured, 8'd0);
      check("rst_dropped", dropped, 8'd0);
      @(negedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;

      // Single store, then one pop
      step(1'b1, 16'd84, 16'h0096, 1'b0);
      check("single_valid", out_valid, 1'b1);
      check("single_data", out_data, 16'h0096);
      check("single_level", level, 3'd1);
      check("single_captured", captured, 8'd1);
      step(1'b0, 16'd0, 16'h0000, 1'b1);
      check("single_drained_valid", out_valid, 1'b0);
      check("single_drained_level", level, 3'd0);

      // Address filter
      do_reset();
      step(1'b1, 16'd80, 16'h1111, 1'b0);
      step(1'b1, 16'd85, 16'h2222, 1'b0);
      step(1'b1, 16'h8054, 16'h3333, 1'b0);
      step(1'b0, 16'd84, 16'h4444, 1'b0);
      check("filter_level", level, 3'd0);
      check("filter_captured", captured, 8'd0);
      check_counters();

      // Overflow
      do_reset();
      for (int i = 1; i <= 5; i++) step(1'b1, 16'd84, 16'(i), 1'b0);
      check("ovf_full", full, 1'b1);
      check("ovf_level", level, 3'd4);
      check("ovf_captured", captured, 8'd4);
      check("ovf_dropped", dropped, 8'd1);
      drain(4);
      check("ovf_empty", out_valid, 1'b0);
      check_counters();

      // Push and pop on the same edge while full; drain order proves wrap
      do_reset();
      step(1'b1, 16'd84, 16'd10, 1'b0);
      step(1'b1, 16'd84, 16'd20, 1'b0);
      step(1'b1, 16'd84, 16'd30, 1'b0);
      step(1'b1, 16'd84, 16'd40, 1'b0);
      step(1'b1, 16'd84, 16'd50, 1'b1);
      check("pp_level", level, 3'd4);
      check("pp_dropped", dropped, 8'd0);
      check("pp_head", out_data, 16'd20);
      drain(4);
      check("pp_empty", out_valid, 1'b0);
      check_counters();

      // Drop counter saturation
      do_reset();
      for (int i = 0; i < 260; i++) step(1'b1, 16'd84, 16'(16'h0100 + i), 1'b0);
      check("sat_dropped", dropped, 8'd255);
      check("sat_captured", captured, 8'd4);
      check_counters();
      drain(4);

      // Reset between edges with a handshake in flight
      do_reset();
      step(1'b1, 16'd84, 16'h0001, 1'b0);
      step(1'b1, 16'd84, 16'h0002, 1'b0);
      step(1'b1, 16'd84, 16'h0003, 1'b0);
      check("mid_level_pre", level, 3'd3);
      memwrite  = 1'b1;
      dataadr   = 16'd84;
      writedata = 16'h0004;
      out_ready = 1'b1;
      #2;
      reset = 1'b0;
      #1;
      check("mid_valid", out_valid, 1'b0);
      check("mid_level", level, 3'd0);
      check("mid_captured", captured, 8'd0);
      model_clear();
      @(posedge clk);
      #1;
      check("mid_held_level", level, 3'd0);
      memwrite  = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      step(1'b1, 16'd84, 16'h00AA, 1'b0);
      check("mid_after_data", out_data, 16'h00AA);
      check("mid_after_captured", captured, 8'd1);
      drain(1);
      check_counters();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
